cp0_exception_ctrl: RTL and testbench
=====================================

Name: cp0_exception_ctrl

Overview:
Coprocessor-0 register file and exception sequencer for the MIPS32 pipeline. It consumes the decoder's CP0 read/write strobes, the syscall flag and an ERET flag, plus hardware interrupt lines. It arbitrates interrupt, syscall and ERET events, updates Status/Cause/EPC/Count/Compare, and drives PC redirect and pipeline flush for a fixed number of cycles.

Parameters:
EXC_VECTOR, 32'h0000_0380, exception entry PC
FLUSH_CYCLES, 2, cycles Flush is held after any accepted event (1..15)
COUNT_DIV, 1, Count increments once every COUNT_DIV cycles (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active-low
CP0WE  in  1  MTC0 write strobe
CP0WAddr  in  5  MTC0 target register
CP0WData  in  32  MTC0 data
CP0RE  in  1  MFC0 read strobe
CP0RAddr  in  5  MFC0 source register
ExcSyscall  in  1  syscall in exception stage
IsEret  in  1  ERET in exception stage
ExcPC  in  32  PC of instruction in exception stage
InDelaySlot  in  1  that instruction is in a branch delay slot
HwInt  in  5  level-sensitive hardware interrupts
CP0RData  out  32  MFC0 read data (0 when CP0RE=0 or unmapped address)
ExcValid  out  1  one-cycle redirect pulse
ExcTarget  out  32  redirect PC, valid with ExcValid
Flush  out  1  squash pipeline
TimerInt  out  1  timer pending (Cause.IP7)

Behaviour:
- Registers: Count=9, Compare=11, Status=12, Cause=13, EPC=14. Other addresses read 0; writes to them are ignored.
- Reset (rst_n=0 at an edge): all CP0 registers 0, FSM=RUN, flush counter 0, every output 0. Reset mid-FLUSH aborts the flush.
- Status writable bits: IM[15:8], EXL[1], IE[0]. All other bits read 0.
- Cause fields:
  - BD[31] and ExcCode[6:2] are hardware-written only.
  - IP[15:10] reflects {timer_pending, HwInt[4:0]} as sampled last cycle.
  - IP[9:8] is software-writable.
- EPC is fully writable.
- Count:
  - Free-runs with wrap 32'hFFFF_FFFF -> 0.
  - A write to Count wins over the increment in the same cycle.
  - The prescaler resets on a Count write.
- Compare and timer:
  - timer_pending sets on the edge after Count==Compare.
  - A write to Compare clears timer_pending and wins over a same-cycle match.
- int_req = IE & ~EXL & |(Cause.IP[15:8] & Status.IM).
- Event acceptance only in state RUN; priority is int_req > ExcSyscall > IsEret.
  - Interrupt: ExcCode=0, EPC=ExcPC, BD=0. The interrupted instruction is re-executed.
  - Syscall:
    - ExcCode=8 and BD=InDelaySlot.
    - If EXL=0: EPC = InDelaySlot ? ExcPC-4 : ExcPC.
    - If EXL=1: EPC is unchanged.
  - For both interrupt and syscall: EXL<=1, target=EXC_VECTOR.
  - ERET: EXL<=0, target=current EPC. Cause is not modified.
  - A same-cycle MTC0 is suppressed when an interrupt or syscall is accepted. It is applied when only ERET is accepted.
- FSM RUN -> FLUSH on acceptance.
  - In the cycle after the accepting edge: ExcValid=1 for exactly 1 cycle, ExcTarget is held until the next acceptance, Flush=1.
  - Flush stays high for FLUSH_CYCLES cycles, then FSM returns to RUN.
  - Events arriving in FLUSH are ignored, since they belong to squashed instructions. MTC0 is also ignored in FLUSH.
  - Count and timer keep running in FLUSH.
- CP0RData is combinational from the current register state, with no same-cycle write bypass. Forwarding is the pipeline's responsibility.

Decomposition:
- Package cp0_defs holds:
  - register address constants (9, 11–14)
  - ExcCode constants (INT=0, SYS=8)
  - Status/Cause bit positions and write masks
  - FSM state encoding {RUN, FLUSH}
- Sub-module cp0_timer owns Count, Compare, the prescaler and timer_pending. It takes the write strobes and data and outputs count, compare and timer_pending.

Test Plan:
1. Hold rst_n=0 2 cycles, release -> reads of addresses 9/11/12/13/14 return 0; Flush=0, ExcValid=0. Write Status=32'hFFFF_FFFF -> reads back 32'h0000_FF03.
2. ExcSyscall=1, ExcPC=32'h0000_1000, InDelaySlot=0 -> next cycle ExcValid=1, ExcTarget=32'h380, Flush high 2 cycles. Status reads 32'h2; Cause reads 32'h20; EPC reads 32'h1000. A second syscall during Flush is ignored.
3. Syscall with ExcPC=32'h2004, InDelaySlot=1 -> EPC=32'h2000, Cause[31]=1. Then ERET -> ExcTarget=32'h2000, EXL=0.
4. Status=32'h8001, Compare=5, Count=0 -> Count reaches 5, TimerInt=1 next edge. Interrupt taken: ExcCode=0, EPC=ExcPC. Write Compare=20 -> TimerInt=0.
5. Same cycle: HwInt[0]=1 with IM10 and IE set, ExcSyscall=1, MTC0 EPC=32'hDEAD -> interrupt wins with ExcCode=0. EPC=ExcPC, not 32'hDEAD.
6. Assert rst_n=0 during the first Flush cycle -> next cycle Flush=0, FSM in RUN, registers 0. A new syscall is accepted immediately after release.

Source files
------------

// File: rtl/cp0_exception_ctrl_pkg.sv
// CP0 register map, exception codes, Status/Cause field layout and sequencer states.
// Shared by the exception sequencer and the Count/Compare timer.
package cp0_exception_ctrl_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_STATUS  = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } cp0_state_t;

   // Cause layout: BD[31], IP[15:8], ExcCode[6:2]; everything else reads 0.
   function automatic logic [31:0] pack_cause(input logic bd, input logic [7:0] ip,
                                              input logic [4:0] code);
      return {bd, 15'b0, ip, 1'b0, code, 2'b00};
   endfunction

endpackage

// File: rtl/cp0_exception_ctrl_if.sv
// Pipeline <-> CP0 bundle: MTC0/MFC0 strobes, exception-stage flags, interrupt lines, redirect.
// The pipeline side is the master; the CP0 block is the slave.
interface cp0_exception_ctrl_if;
   logic        CP0WE;
   logic [4:0]  CP0WAddr;
   logic [31:0] CP0WData;
   logic        CP0RE;
   logic [4:0]  CP0RAddr;
   logic        ExcSyscall;
   logic        IsEret;
   logic [31:0] ExcPC;
   logic        InDelaySlot;
   logic [4:0]  HwInt;
   logic [31:0] CP0RData;
   logic        ExcValid;
   logic [31:0] ExcTarget;
   logic        Flush;
   logic        TimerInt;

   modport master (
      output CP0WE, CP0WAddr, CP0WData, CP0RE, CP0RAddr,
             ExcSyscall, IsEret, ExcPC, InDelaySlot, HwInt,
      input  CP0RData, ExcValid, ExcTarget, Flush, TimerInt
   );

   modport slave (
      input  CP0WE, CP0WAddr, CP0WData, CP0RE, CP0RAddr,
             ExcSyscall, IsEret, ExcPC, InDelaySlot, HwInt,
      output CP0RData, ExcValid, ExcTarget, Flush, TimerInt
   );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare match sets timer_pending.
// Writes land on the next edge; no backpressure.
module cp0_timer #(
   parameter int COUNT_DIV = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        timer_pending
);
   import cp0_exception_ctrl_pkg::*;

   localparam logic [7:0] DIV_LAST = 8'(COUNT_DIV - 1);

   logic [7:0] prescale;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count         <= '0;
         compare       <= '0;
         prescale      <= '0;
         timer_pending <= 1'b0;
      end else begin
         // A software write restarts the prescale period along with Count.
         if (count_we) begin
            count    <= wdata;
            prescale <= '0;
         end else if (prescale == DIV_LAST) begin
            count    <= count + 32'd1;
            prescale <= '0;
         end else begin
            prescale <= prescale + 8'd1;
         end

         if (compare_we) begin
            compare       <= wdata;
            timer_pending <= 1'b0;
         end else if (count == compare) begin
            timer_pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 register file and exception sequencer: arbitrates interrupt > syscall > ERET, redirects PC.
// Redirect one cycle after acceptance, Flush held FLUSH_CYCLES; events/MTC0 during flush are dropped.
module cp0_exception_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0380,
   parameter int          FLUSH_CYCLES = 2,
   parameter int          COUNT_DIV    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cp0_exception_ctrl_if.slave  bus
);
   import cp0_exception_ctrl_pkg::*;

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   cp0_state_t  state;
   logic [3:0]  flush_cnt;
   logic [31:0] status_q;
   logic        cause_bd;
   logic [5:0]  cause_ip_hw;
   logic [1:0]  cause_ip_sw;
   logic [4:0]  cause_code;
   logic [31:0] epc;
   logic        exc_valid;
   logic [31:0] exc_target;
   logic        flush;

   logic [31:0] count;
   logic [31:0] compare;
   logic        timer_pending;

   logic [7:0]  cause_ip;
   logic [31:0] cause_val;
   logic        int_req;
   logic        in_run;
   logic        take_int;
   logic        take_sys;
   logic        take_eret;
   logic        take_exc;
   logic        accept;
   logic        wr_en;
   logic [31:0] sys_epc;
   logic [31:0] rdata;

   assign cause_ip  = {cause_ip_hw, cause_ip_sw};
   assign cause_val = pack_cause(cause_bd, cause_ip, cause_code);
   assign int_req   = status_q[ST_IE] & ~status_q[ST_EXL] & (|(cause_ip & status_q[15:8]));

   assign in_run    = (state == RUN);
   assign take_int  = in_run & int_req;
   assign take_sys  = in_run & ~int_req & bus.ExcSyscall;
   assign take_eret = in_run & ~int_req & ~bus.ExcSyscall & bus.IsEret;
   assign take_exc  = take_int | take_sys;
   assign accept    = take_exc | take_eret;

   // MTC0 belongs to the instruction being squashed when an exception is taken.
   assign wr_en   = bus.CP0WE & in_run & ~take_exc;
   assign sys_epc = bus.InDelaySlot ? (bus.ExcPC - 32'd4) : bus.ExcPC;

   cp0_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk           (clk),
      .rst_n         (rst_n),
      .count_we      (wr_en & (bus.CP0WAddr == CP0_COUNT)),
      .compare_we    (wr_en & (bus.CP0WAddr == CP0_COMPARE)),
      .wdata         (bus.CP0WData),
      .count         (count),
      .compare       (compare),
      .timer_pending (timer_pending)
   );

   always_comb begin
      rdata = '0;
      if (bus.CP0RE) begin
         case (bus.CP0RAddr)
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
            CP0_STATUS:  rdata = status_q;
            CP0_CAUSE:   rdata = cause_val;
            CP0_EPC:     rdata = epc;
            default:     rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         flush_cnt   <= '0;
         status_q    <= '0;
         cause_bd    <= 1'b0;
         cause_ip_hw <= '0;
         cause_ip_sw <= '0;
         cause_code  <= '0;
         epc         <= '0;
         exc_valid   <= 1'b0;
         exc_target  <= '0;
         flush       <= 1'b0;
      end else begin
         cause_ip_hw <= {timer_pending, bus.HwInt};

         if (wr_en && bus.CP0WAddr == CP0_STATUS) status_q    <= bus.CP0WData & STATUS_WMASK;
         if (wr_en && bus.CP0WAddr == CP0_CAUSE)  cause_ip_sw <= bus.CP0WData[9:8];
         if (wr_en && bus.CP0WAddr == CP0_EPC)    epc         <= bus.CP0WData;

         // Event updates come last so they override any same-cycle MTC0 field.
         if (take_int) begin
            cause_code       <= EXC_INT;
            cause_bd         <= 1'b0;
            epc              <= bus.ExcPC;
            status_q[ST_EXL] <= 1'b1;
         end
         if (take_sys) begin
            cause_code       <= EXC_SYS;
            cause_bd         <= bus.InDelaySlot;
            if (!status_q[ST_EXL]) epc <= sys_epc;
            status_q[ST_EXL] <= 1'b1;
         end
         if (take_eret) status_q[ST_EXL] <= 1'b0;

         exc_valid <= accept;
         if (accept) exc_target <= take_eret ? epc : EXC_VECTOR;

         case (state)
            RUN: begin
               if (accept) begin
                  state     <= FLUSH;
                  flush     <= 1'b1;
                  flush_cnt <= FLUSH_LAST;
               end
            end
            FLUSH: begin
               if (flush_cnt == 4'd0) begin
                  state <= RUN;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
         endcase
      end
   end

   assign bus.CP0RData  = rdata;
   assign bus.ExcValid  = exc_valid;
   assign bus.ExcTarget = exc_target;
   assign bus.Flush     = flush;
   assign bus.TimerInt  = cause_ip_hw[5];

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Bench for cp0_exception_ctrl: directed scenarios then random traffic, all cycles checked
// against a word-level CP0 model.
module tb_cp0_exception_ctrl;

   localparam logic [31:0] VEC = 32'h0000_0380;
   localparam int FC  = 2;
   localparam int DIV = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cp0_exception_ctrl_if bus ();

   cp0_exception_ctrl #(
      .EXC_VECTOR   (VEC),
      .FLUSH_CYCLES (FC),
      .COUNT_DIV    (DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference state: architectural registers as whole 32-bit words.
   logic [31:0] m_status, m_cause, m_epc, m_count, m_compare, m_target;
   logic        m_pend, m_valid;
   int          m_pre, m_flush_left;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
      if (!re) return 32'h0;
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge();
      logic [31:0] ns, nc, ne, ncnt, ncmp;
      logic np;
      bit idle, irq, ti, ts, te, wr;
      if (!rst_n) begin
         m_status = '0; m_cause = '0; m_epc = '0; m_count = '0; m_compare = '0;
         m_pend = 1'b0; m_pre = 0; m_flush_left = 0; m_valid = 1'b0; m_target = '0;
         return;
      end
      ns = m_status; nc = m_cause; ne = m_epc; ncnt = m_count; ncmp = m_compare; np = m_pend;
      idle = (m_flush_left == 0);
      irq  = m_status[0] && !m_status[1] && ((m_cause[15:8] & m_status[15:8]) != 8'h00);
      ti   = idle && irq;
      ts   = idle && !irq && bus.ExcSyscall;
      te   = idle && !irq && !bus.ExcSyscall && bus.IsEret;
      wr   = bus.CP0WE && idle && !ti && !ts;

      if (wr && bus.CP0WAddr == 5'd9) begin
         ncnt = bus.CP0WData;
         m_pre = 0;
      end else begin
         m_pre++;
         if (m_pre >= DIV) begin
            ncnt = m_count + 32'd1;
            m_pre = 0;
         end
      end
      if (wr && bus.CP0WAddr == 5'd11) begin
         ncmp = bus.CP0WData;
         np = 1'b0;
      end else if (m_count == m_compare) begin
         np = 1'b1;
      end
      if (wr && bus.CP0WAddr == 5'd12) ns = bus.CP0WData & 32'h0000_FF03;
      if (wr && bus.CP0WAddr == 5'd13) nc[9:8] = bus.CP0WData[9:8];
      if (wr && bus.CP0WAddr == 5'd14) ne = bus.CP0WData;
      nc[15:10] = {m_pend, bus.HwInt};

      if (ti) begin
         nc[31] = 1'b0; nc[6:2] = 5'd0; ne = bus.ExcPC; ns[1] = 1'b1;
      end
      if (ts) begin
         nc[31] = bus.InDelaySlot; nc[6:2] = 5'd8;
         if (!m_status[1]) ne = bus.InDelaySlot ? bus.ExcPC - 32'd4 : bus.ExcPC;
         ns[1] = 1'b1;
      end
      if (te) ns[1] = 1'b0;

      m_valid = ti || ts || te;
      if (ti || ts) m_target = VEC;
      else if (te) m_target = m_epc;
      if (m_valid) m_flush_left = FC;
      else if (m_flush_left > 0) m_flush_left--;

      m_status = ns; m_cause = nc; m_epc = ne; m_count = ncnt; m_compare = ncmp; m_pend = np;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("flush", {31'b0, bus.Flush}, {31'b0, m_flush_left > 0});
      chk("exc_valid", {31'b0, bus.ExcValid}, {31'b0, m_valid});
      chk("exc_target", bus.ExcTarget, m_target);
      chk("timer_int", {31'b0, bus.TimerInt}, {31'b0, m_cause[15]});
      chk("rdata", bus.CP0RData, m_read(bus.CP0RE, bus.CP0RAddr));
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.CP0WE = 1'b1; bus.CP0WAddr = a; bus.CP0WData = d;
      tick();
      bus.CP0WE = 1'b0;
   endtask

   task automatic read_reg(input logic [4:0] a, input logic [31:0] exp, input string tag);
      bus.CP0RE = 1'b1; bus.CP0RAddr = a;
      #1;
      chk(tag, bus.CP0RData, exp);
   endtask

   initial begin
      int n;
      logic [4:0] addr_tab [6];
      bus.CP0WE = 0; bus.CP0WAddr = 0; bus.CP0WData = 0; bus.CP0RE = 0; bus.CP0RAddr = 0;
      bus.ExcSyscall = 0; bus.IsEret = 0; bus.ExcPC = 0; bus.InDelaySlot = 0; bus.HwInt = 0;

      // 1: reset, Status write mask
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      chk("rst_flush", {31'b0, bus.Flush}, 32'h0);
      chk("rst_valid", {31'b0, bus.ExcValid}, 32'h0);
      read_reg(5'd9,  32'h0, "rst_count");
      read_reg(5'd11, 32'h0, "rst_compare");
      read_reg(5'd12, 32'h0, "rst_status");
      read_reg(5'd13, 32'h0, "rst_cause");
      read_reg(5'd14, 32'h0, "rst_epc");
      mtc0(5'd11, 32'h8000_0000);
      mtc0(5'd12, 32'hFFFF_FFFF);
      read_reg(5'd12, 32'h0000_FF03, "status_mask");
      mtc0(5'd12, 32'h0);

      // 2: syscall, second syscall during flush ignored
      bus.ExcSyscall = 1; bus.ExcPC = 32'h1000; bus.InDelaySlot = 0;
      tick();
      chk("sys_valid", {31'b0, bus.ExcValid}, 32'h1);
      chk("sys_target", bus.ExcTarget, 32'h380);
      chk("sys_flush1", {31'b0, bus.Flush}, 32'h1);
      bus.ExcPC = 32'h3000;
      tick();
      chk("sys_ignored", {31'b0, bus.ExcValid}, 32'h0);
      chk("sys_flush2", {31'b0, bus.Flush}, 32'h1);
      bus.ExcSyscall = 0;
      tick();
      chk("sys_flush_end", {31'b0, bus.Flush}, 32'h0);
      read_reg(5'd12, 32'h2, "sys_status");
      read_reg(5'd13, 32'h20, "sys_cause");
      read_reg(5'd14, 32'h1000, "sys_epc");

      // 3: delay-slot syscall then ERET
      mtc0(5'd12, 32'h0);
      bus.ExcSyscall = 1; bus.ExcPC = 32'h2004; bus.InDelaySlot = 1;
      tick();
      bus.ExcSyscall = 0; bus.InDelaySlot = 0;
      tick(); tick();
      read_reg(5'd14, 32'h2000, "ds_epc");
      read_reg(5'd13, 32'h8000_0020, "ds_cause");
      bus.IsEret = 1;
      tick();
      chk("eret_valid", {31'b0, bus.ExcValid}, 32'h1);
      chk("eret_target", bus.ExcTarget, 32'h2000);
      bus.IsEret = 0;
      tick(); tick();
      read_reg(5'd12, 32'h0, "eret_status");

      // 4: timer interrupt
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      mtc0(5'd12, 32'h8001);
      bus.ExcPC = 32'h4000;
      n = 1;
      while (!bus.TimerInt && n < 40) begin
         tick();
         n++;
      end
      chk("timer_latency", n, 7);
      tick();
      chk("tint_valid", {31'b0, bus.ExcValid}, 32'h1);
      chk("tint_target", bus.ExcTarget, 32'h380);
      tick(); tick();
      read_reg(5'd13, 32'h0000_8000, "tint_cause");
      read_reg(5'd14, 32'h4000, "tint_epc");
      read_reg(5'd12, 32'h8003, "tint_status");
      mtc0(5'd11, 32'd20);
      tick();
      chk("timer_clear", {31'b0, bus.TimerInt}, 32'h0);
      mtc0(5'd12, 32'h0);

      // 5: interrupt beats syscall and suppresses same-cycle MTC0
      mtc0(5'd12, 32'h0401);
      bus.HwInt = 5'd1;
      tick();
      bus.ExcSyscall = 1; bus.ExcPC = 32'h5000;
      bus.CP0WE = 1; bus.CP0WAddr = 5'd14; bus.CP0WData = 32'hDEAD;
      tick();
      chk("prio_valid", {31'b0, bus.ExcValid}, 32'h1);
      bus.CP0WE = 0; bus.ExcSyscall = 0; bus.HwInt = 0;
      tick(); tick();
      read_reg(5'd14, 32'h5000, "prio_epc");
      read_reg(5'd13, m_cause, "prio_cause");
      chk("prio_code", {27'b0, bus.CP0RData[6:2]}, 32'h0);
      mtc0(5'd12, 32'h0);

      // 6: reset during flush
      bus.ExcSyscall = 1; bus.ExcPC = 32'h6000;
      tick();
      chk("r6_flush", {31'b0, bus.Flush}, 32'h1);
      bus.ExcSyscall = 0; rst_n = 1'b0;
      tick();
      chk("r6_flush_abort", {31'b0, bus.Flush}, 32'h0);
      read_reg(5'd12, 32'h0, "r6_status");
      read_reg(5'd14, 32'h0, "r6_epc");
      rst_n = 1'b1; bus.ExcSyscall = 1; bus.ExcPC = 32'h7000;
      tick();
      chk("r6_accept", {31'b0, bus.ExcValid}, 32'h1);
      bus.ExcSyscall = 0;
      tick(); tick();
      read_reg(5'd14, 32'h7000, "r6_epc_new");

      // Random traffic
      addr_tab[0] = 5'd9;  addr_tab[1] = 5'd11; addr_tab[2] = 5'd12;
      addr_tab[3] = 5'd13; addr_tab[4] = 5'd14; addr_tab[5] = 5'd3;
      for (int i = 0; i < 3000; i++) begin
         rst_n           = ($urandom_range(0, 299) != 0);
         bus.CP0WE       = ($urandom_range(0, 3) == 0);
         bus.CP0WAddr    = addr_tab[$urandom_range(0, 5)];
         bus.CP0WData    = $urandom;
         if (bus.CP0WAddr == 5'd11) bus.CP0WData = m_count + 32'($urandom_range(0, 12));
         if (bus.CP0WAddr == 5'd5 || $urandom_range(0, 9) == 0) bus.CP0WAddr = 5'($urandom);
         bus.CP0RE       = ($urandom_range(0, 3) != 0);
         bus.CP0RAddr    = ($urandom_range(0, 5) == 0) ? 5'($urandom) : addr_tab[$urandom_range(0, 4)];
         bus.ExcSyscall  = ($urandom_range(0, 7) == 0);
         bus.IsEret      = ($urandom_range(0, 7) == 0);
         bus.ExcPC       = $urandom;
         bus.InDelaySlot = 1'($urandom);
         bus.HwInt       = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'd0;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
